bounce_ctrl: RTL and testbench
==============================

BOUNCE_CTRL -- requirements
Module: bounce_ctrl

Interface
REQ-001 Parameter FLOOR, default 8'd100: ball y at which a landing is evaluated.
REQ-002 Parameter UP_FRAMES, default 7'd65: frames of upward travel after a successful bounce.
REQ-003 Parameter BALL_RESET_COLOR, default 3'b111: ball colour after reset or restart.
REQ-004 Port clk, input, 1: sole clock, all state on rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low; 0 clears all state immediately.
REQ-006 Port start, input, 1: level, begins or restarts a game (sampled only in IDLE/OVER).
REQ-007 Port frame_tick, input, 1: one-cycle pulse, one game step per pulse.
REQ-008 Port player_color, input, 3: colour selected by the player.
REQ-009 Port color_plats, input, 12: four platform colours, platform i at bits [3i+2:3i].
REQ-010 Port draw_ack, input, 1: renderer finished the current frame.
REQ-011 Ports prev_ball, curr_ball, output, 8 each: previous and current ball y, registered.
REQ-012 Port color_ball, output, 3: ball colour, registered.
REQ-013 Port score, output, 16: registered score.
REQ-014 Port draw_req, output, 1: request to renderer, held until draw_ack.
REQ-015 Ports game_over, overrun, output, 1 each: game-ended flag; sticky dropped-tick flag.

Function
REQ-016 FSM states: IDLE, WAIT_TICK, MOVE, CHECK, DRAW, OVER; one-hot or binary at implementer's choice.
REQ-017 IDLE: start=1 -> WAIT_TICK next cycle; otherwise stay.
REQ-018 WAIT_TICK: frame_tick=1 -> MOVE next cycle.
REQ-019 MOVE (1 cycle): prev_ball<=curr_ball; color_ball<=player_color; dir down -> curr_ball+1, saturating at FLOOR; dir up -> curr_ball-1 (saturating at 0), up_cnt-1, up_cnt reaching 0 -> dir down; -> CHECK.
REQ-020 CHECK (1 cycle): if dir down and curr_ball==FLOOR, compare color_ball with platform plat_idx colour.
REQ-021 Match: score+1 saturating at 16'hFFFF, plat_idx+1 modulo 4, dir up, up_cnt<=UP_FRAMES; -> DRAW.
REQ-022 Mismatch: set pending-over flag; -> DRAW. Not at FLOOR: -> DRAW, no score change.
REQ-023 DRAW: draw_req=1; on draw_ack=1 draw_req drops next cycle, -> OVER if pending-over else WAIT_TICK.
REQ-024 draw_ack outside DRAW is ignored; draw_req never asserts outside DRAW.
REQ-025 frame_tick seen in MOVE/CHECK/DRAW is dropped and sets overrun; overrun clears only on reset or restart.
REQ-026 OVER: game_over=1, outputs hold; start=1 -> restart: curr_ball, prev_ball, score, plat_idx, up_cnt cleared, dir down, color_ball=BALL_RESET_COLOR, overrun and game_over cleared, -> WAIT_TICK.
REQ-027 start is ignored in WAIT_TICK, MOVE, CHECK and DRAW.
REQ-028 Tick-to-draw_req latency: exactly 3 cycles (tick cycle, MOVE, CHECK; draw_req high in 4th).

Reset
REQ-029 reset=0 asynchronously forces: state IDLE, prev_ball=0, curr_ball=0, color_ball=BALL_RESET_COLOR, score=0, plat_idx=0, up_cnt=0, dir down, draw_req=0, game_over=0, overrun=0, pending-over=0.
REQ-030 Reset mid-DRAW drops draw_req in the same cycle; release is synchronised so the first active edge sees stable state.

Structure
REQ-031 Package color_bounce_pkg holds the state enum, FLOOR, UP_FRAMES, BALL_RESET_COLOR and platform-field width (3).
REQ-032 One sub-module, bounce_motion, holds curr/prev ball, direction and up_cnt; the FSM and scoring stay in bounce_ctrl.
REQ-033 Outputs are registered and feed the existing game-state memory register directly; no combinational path from inputs to outputs.

Verification
REQ-034 Reset, start=1, one tick, draw_ack -> curr_ball=1, prev_ball=0, score=0, draw_req high in cycle 4 after tick.
REQ-035 player_color=3'b010, color_plats[2:0]=3'b010, 100 ticks -> score=1, plat_idx=1, dir up; next 65 ticks -> curr_ball=35, then falling.
REQ-036 player_color=3'b100, color_plats[2:0]=3'b001, 100 ticks -> game_over=1 after draw_ack; further ticks change nothing; start -> all outputs reset values, color_ball=3'b111.
REQ-037 Hold draw_ack=0 for 10 cycles, pulse frame_tick during DRAW -> draw_req stays high, overrun=1, curr_ball unchanged by extra tick.
REQ-038 Preload score=16'hFFFF path via forced match -> score stays 16'hFFFF.
REQ-039 reset=0 asserted while draw_req=1 -> draw_req=0 without a clock edge; all outputs at REQ-029 values.

Source files
------------

// File: rtl/color_bounce_pkg.sv
// Shared constants, state encoding and helpers for the bounce game.
// Imported by bounce_ctrl and bounce_motion.
package color_bounce_pkg;

    localparam int PLAT_W    = 3;
    localparam int NUM_PLATS = 4;

    localparam logic [7:0] FLOOR_DEF            = 8'd100;
    localparam logic [6:0] UP_FRAMES_DEF        = 7'd65;
    localparam logic [2:0] BALL_RESET_COLOR_DEF = 3'b111;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_WAIT  = 3'd1;
    localparam state_t S_MOVE  = 3'd2;
    localparam state_t S_CHECK = 3'd3;
    localparam state_t S_DRAW  = 3'd4;
    localparam state_t S_OVER  = 3'd5;

    function automatic logic [PLAT_W-1:0] plat_color(
        input logic [NUM_PLATS*PLAT_W-1:0] plats,
        input logic [1:0]                  idx
    );
        return plats[int'(idx)*PLAT_W +: PLAT_W];
    endfunction

endpackage

// File: rtl/bounce_motion.sv
// Ball vertical motion: current/previous y, direction and rise counter.
// Ports: clk, rst_n, clear (restart), move_en (one step), bounce (start rise), prev/curr ball, dir_up.
module bounce_motion
    import color_bounce_pkg::*;
#(
    parameter logic [7:0] FLOOR     = FLOOR_DEF,
    parameter logic [6:0] UP_FRAMES = UP_FRAMES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       move_en,
    input  logic       bounce,
    output logic [7:0] prev_ball,
    output logic [7:0] curr_ball,
    output logic       dir_up
);

    logic [7:0] prev_q, prev_d;
    logic [7:0] curr_q, curr_d;
    logic       up_q, up_d;
    logic [6:0] cnt_q, cnt_d;

    always_comb begin
        prev_d = prev_q;
        curr_d = curr_q;
        up_d   = up_q;
        cnt_d  = cnt_q;
        if (clear) begin
            prev_d = 8'd0;
            curr_d = 8'd0;
            up_d   = 1'b0;
            cnt_d  = 7'd0;
        end else if (bounce) begin
            up_d  = 1'b1;
            cnt_d = UP_FRAMES;
        end else if (move_en) begin
            prev_d = curr_q;
            if (up_q) begin
                curr_d = (curr_q == 8'd0) ? 8'd0 : curr_q - 8'd1;
                cnt_d  = (cnt_q == 7'd0) ? 7'd0 : cnt_q - 7'd1;
                // last rise frame turns the ball around
                if (cnt_q <= 7'd1) up_d = 1'b0;
            end else begin
                curr_d = (curr_q >= FLOOR) ? FLOOR : curr_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 8'd0;
            curr_q <= 8'd0;
            up_q   <= 1'b0;
            cnt_q  <= 7'd0;
        end else begin
            prev_q <= prev_d;
            curr_q <= curr_d;
            up_q   <= up_d;
            cnt_q  <= cnt_d;
        end
    end

    assign prev_ball = prev_q;
    assign curr_ball = curr_q;
    assign dir_up    = up_q;

endmodule

// File: rtl/bounce_ctrl.sv
// Game FSM, landing/scoring and renderer handshake for the bounce game.
// Ports: clk, reset (async low), start, frame_tick, player_color, color_plats, draw_ack -> ball/score/draw/status.
module bounce_ctrl
    import color_bounce_pkg::*;
#(
    parameter logic [7:0] FLOOR            = FLOOR_DEF,
    parameter logic [6:0] UP_FRAMES        = UP_FRAMES_DEF,
    parameter logic [2:0] BALL_RESET_COLOR = BALL_RESET_COLOR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        frame_tick,
    input  logic [2:0]  player_color,
    input  logic [11:0] color_plats,
    input  logic        draw_ack,
    output logic [7:0]  prev_ball,
    output logic [7:0]  curr_ball,
    output logic [2:0]  color_ball,
    output logic [15:0] score,
    output logic        draw_req,
    output logic        game_over,
    output logic        overrun
);

    // assert asynchronously, release on the second clock edge
    logic rst_meta_q, rst_n_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_meta_q <= 1'b0;
            rst_n_q    <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_n_q    <= rst_meta_q;
        end
    end

    state_t      state_q, state_d;
    logic [2:0]  color_q, color_d;
    logic [15:0] score_q, score_d;
    logic [1:0]  plat_q, plat_d;
    logic        pend_q, pend_d;
    logic        draw_q, draw_d;
    logic        over_q, over_d;
    logic        ovr_q, ovr_d;

    logic move_en, bounce, clear, dir_up;

    always_comb begin
        state_d = state_q;
        color_d = color_q;
        score_d = score_q;
        plat_d  = plat_q;
        pend_d  = pend_q;
        draw_d  = draw_q;
        over_d  = over_q;
        ovr_d   = ovr_q;
        move_en = 1'b0;
        bounce  = 1'b0;
        clear   = 1'b0;
        if (frame_tick &&
            (state_q == S_MOVE || state_q == S_CHECK || state_q == S_DRAW))
            ovr_d = 1'b1;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_WAIT;
            S_WAIT: if (frame_tick) state_d = S_MOVE;
            S_MOVE: begin
                move_en = 1'b1;
                color_d = player_color;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                state_d = S_DRAW;
                draw_d  = 1'b1;
                if (!dir_up && curr_ball == FLOOR) begin
                    if (color_q == plat_color(color_plats, plat_q)) begin
                        score_d = (score_q == 16'hFFFF) ? score_q
                                                        : score_q + 16'd1;
                        plat_d  = plat_q + 2'd1;
                        bounce  = 1'b1;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
            end
            S_DRAW: if (draw_ack) begin
                draw_d = 1'b0;
                if (pend_q) begin
                    state_d = S_OVER;
                    over_d  = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_OVER: if (start) begin
                clear   = 1'b1;
                color_d = BALL_RESET_COLOR;
                score_d = 16'd0;
                plat_d  = 2'd0;
                pend_d  = 1'b0;
                over_d  = 1'b0;
                ovr_d   = 1'b0;
                state_d = S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            state_q <= S_IDLE;
            color_q <= BALL_RESET_COLOR;
            score_q <= 16'd0;
            plat_q  <= 2'd0;
            pend_q  <= 1'b0;
            draw_q  <= 1'b0;
            over_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            color_q <= color_d;
            score_q <= score_d;
            plat_q  <= plat_d;
            pend_q  <= pend_d;
            draw_q  <= draw_d;
            over_q  <= over_d;
            ovr_q   <= ovr_d;
        end
    end

    bounce_motion #(
        .FLOOR     (FLOOR),
        .UP_FRAMES (UP_FRAMES)
    ) u_motion (
        .clk       (clk),
        .rst_n     (rst_n_q),
        .clear     (clear),
        .move_en   (move_en),
        .bounce    (bounce),
        .prev_ball (prev_ball),
        .curr_ball (curr_ball),
        .dir_up    (dir_up)
    );

    assign color_ball = color_q;
    assign score      = score_q;
    assign draw_req   = draw_q;
    assign game_over  = over_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_bounce_ctrl.sv
// Self-checking bench for bounce_ctrl: per-cycle game model plus directed scenarios.
// Drives on falling edges, compares on falling edges.
module tb_bounce_ctrl;

    localparam int FLOOR = 100;
    localparam int UPF   = 65;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        frame_tick = 1'b0;
    logic [2:0]  player_color = 3'd0;
    logic [11:0] color_plats = 12'd0;
    logic        draw_ack = 1'b0;
    logic [7:0]  prev_ball, curr_ball;
    logic [2:0]  color_ball;
    logic [15:0] score;
    logic        draw_req, game_over, overrun;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bounce_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .frame_tick   (frame_tick),
        .player_color (player_color),
        .color_plats  (color_plats),
        .draw_ack     (draw_ack),
        .prev_ball    (prev_ball),
        .curr_ball    (curr_ball),
        .color_ball   (color_ball),
        .score        (score),
        .draw_req     (draw_req),
        .game_over    (game_over),
        .overrun      (overrun)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // game model: phase 0 idle, 1 wait tick, 2 move, 3 check, 4 draw, 5 over
    int m_phase, m_hold;
    int m_curr, m_prev, m_color, m_score, m_idx, m_left;
    bit m_up, m_lost, m_draw, m_over, m_ovr;

    task automatic model_clear();
        m_curr  = 0;
        m_prev  = 0;
        m_color = 7;
        m_score = 0;
        m_idx   = 0;
        m_left  = 0;
        m_up    = 0;
        m_lost  = 0;
        m_draw  = 0;
        m_over  = 0;
        m_ovr   = 0;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_clear();
            m_phase = 0;
            m_hold  = 2;
        end else if (m_hold > 0) begin
            m_hold--;
        end else begin
            if (frame_tick && m_phase >= 2 && m_phase <= 4) m_ovr = 1;
            case (m_phase)
                0: if (start) m_phase = 1;
                1: if (frame_tick) m_phase = 2;
                2: begin
                    m_prev  = m_curr;
                    m_color = int'(player_color);
                    if (m_up) begin
                        if (m_curr > 0) m_curr--;
                        m_left--;
                        if (m_left <= 0) m_up = 0;
                    end else if (m_curr < FLOOR) begin
                        m_curr++;
                    end
                    m_phase = 3;
                end
                3: begin
                    if (!m_up && m_curr == FLOOR) begin
                        if (m_color == int'((color_plats >> (3 * m_idx)) & 12'h7)) begin
                            if (m_score < 65535) m_score++;
                            m_idx  = (m_idx + 1) % 4;
                            m_up   = 1;
                            m_left = UPF;
                        end else begin
                            m_lost = 1;
                        end
                    end
                    m_draw  = 1;
                    m_phase = 4;
                end
                4: if (draw_ack) begin
                    m_draw = 0;
                    if (m_lost) begin
                        m_over  = 1;
                        m_phase = 5;
                    end else begin
                        m_phase = 1;
                    end
                end
                5: if (start) begin
                    model_clear();
                    m_phase = 1;
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        check("curr_ball", int'(curr_ball), m_curr);
        check("prev_ball", int'(prev_ball), m_prev);
        check("color_ball", int'(color_ball), m_color);
        check("score", int'(score), m_score);
        check("draw_req", int'(draw_req), int'(m_draw));
        check("game_over", int'(game_over), int'(m_over));
        check("overrun", int'(overrun), int'(m_ovr));
    end

    // one game frame; returns tick-to-draw_req latency and draw_req just before ack
    task automatic frame(input bit extra, input int hold,
                         output int lat, output bit dr_before);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        lat = 1;
        while (!draw_req && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        if (!draw_req) check("draw_req_timeout", 0, 1);
        for (int i = 0; i < hold; i++) begin
            frame_tick = (extra && i == 0);
            @(negedge clk);
            frame_tick = 1'b0;
        end
        dr_before = draw_req;
        draw_ack = 1'b1;
        @(negedge clk);
        draw_ack = 1'b0;
    endtask

    task automatic frames(input int n);
        int l;
        bit d;
        for (int i = 0; i < n; i++) frame(1'b0, 0, l, d);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  drb;
        int  held;
        repeat (3) @(negedge clk);
        check("rst_curr", int'(curr_ball), 0);
        check("rst_color", int'(color_ball), 7);
        check("rst_draw_req", int'(draw_req), 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // first frame: latency and first step down
        player_color = 3'b010;
        color_plats  = 12'b000_000_000_010;
        pulse_start();
        frame(1'b0, 0, lat, drb);
        check("latency", lat, 3);
        check("first_curr", int'(curr_ball), 1);
        check("first_prev", int'(prev_ball), 0);
        check("first_score", int'(score), 0);

        // matching landing, then full rise and turn-around
        frames(99);
        check("land_score", int'(score), 1);
        check("land_curr", int'(curr_ball), 100);
        frames(65);
        check("apex_curr", int'(curr_ball), 35);
        frames(1);
        check("fall_curr", int'(curr_ball), 36);

        // stalled renderer plus dropped tick
        frame(1'b1, 10, lat, drb);
        check("held_draw_req", int'(drb), 1);
        check("overrun_set", int'(overrun), 1);
        check("no_extra_move", int'(curr_ball), 37);

        // mismatching landing ends the game
        do_reset();
        player_color = 3'b100;
        color_plats  = 12'b000_000_000_001;
        pulse_start();
        frames(99);
        frame(1'b1, 2, lat, drb);
        check("over_flag", int'(game_over), 1);
        check("over_curr", int'(curr_ball), 100);
        held = int'(curr_ball);
        for (int i = 0; i < 3; i++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            repeat (3) @(negedge clk);
        end
        check("over_hold", int'(curr_ball), held);
        check("over_no_draw", int'(draw_req), 0);

        // restart clears everything; start held high is then ignored
        start = 1'b1;
        @(negedge clk);
        check("rs_curr", int'(curr_ball), 0);
        check("rs_prev", int'(prev_ball), 0);
        check("rs_score", int'(score), 0);
        check("rs_color", int'(color_ball), 7);
        check("rs_over", int'(game_over), 0);
        check("rs_overrun", int'(overrun), 0);
        frames(2);
        start = 1'b0;
        check("start_ignored", int'(curr_ball), 2);

        // saturated score through a matching landing
        player_color = 3'b010;
        color_plats  = 12'b000_000_000_010;
        #1;
        force dut.score_q = 16'hFFFF;
        m_score = 65535;
        @(negedge clk);
        release dut.score_q;
        frames(98);
        check("sat_curr", int'(curr_ball), 100);
        check("sat_score", int'(score), 65535);
        check("sat_not_over", int'(game_over), 0);

        // asynchronous reset while drawing
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_draw", int'(draw_req), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_draw_req", int'(draw_req), 0);
        check("async_curr", int'(curr_ball), 0);
        check("async_prev", int'(prev_ball), 0);
        check("async_score", int'(score), 0);
        check("async_color", int'(color_ball), 7);
        check("async_over", int'(game_over), 0);
        check("async_overrun", int'(overrun), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
